// File: rtl/gate_cmd_receiver.sv
// Receives addressed gate-pattern bytes from uart_rx and applies them to six gate drives
// on each shoot edge, with dead-time and a watchdog. Optional echo to uart_tx: GATE_ECHO_EN.
module gate_cmd_receiver #(
  parameter logic [1:0] MODULE_ID = 2'd0,
  parameter int         DEADTIME  = 48,
  parameter int         TIMEOUT   = 4800000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_received,
  input  logic       rx_done,
  input  logic       parity_error,
  input  logic       shoot,
`ifdef GATE_ECHO_EN
  input  logic       tx_busy,
  output logic [7:0] data_to_tx,
  output logic       start_tx,
`endif
  output logic [5:0] gate,
  output logic       armed,
  output logic       frame_err,
  output logic       fault,
  output logic [1:0] state_dbg
);

  localparam int DT_W = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DEAD  = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [5:0]        shadow;
  logic [5:0]        next_q, next_d;
  logic [5:0]        gate_d;
  logic [DT_W-1:0]   cnt, cnt_d;
  logic [WD_W-1:0]   wd, wd_d;
  logic              fault_d;
  logic              take;
  logic              launch;

  // Byte interface: rx_done is a valid strobe with no ready; a byte is consumed
  // in the cycle rx_done=1 and parity_error qualifies that same cycle.
  logic addr_hit, both_on, accept, reject;
  assign addr_hit = (data_received[7:6] == MODULE_ID);
  assign both_on  = (data_received[0] & data_received[1]) |
                    (data_received[2] & data_received[3]) |
                    (data_received[4] & data_received[5]);
  assign accept   = rx_done & ~parity_error & addr_hit & ~both_on;
  assign reject   = rx_done & (parity_error | (addr_hit & both_on));

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow    <= '0;
      armed     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (accept) shadow <= data_received[5:0];
      // A byte arriving with a shoot still leaves a pattern pending for the next shoot.
      if (accept)    armed <= 1'b1;
      else if (take) armed <= 1'b0;
      if (accept)      frame_err <= 1'b0;
      else if (reject) frame_err <= 1'b1;
    end
  end

  logic s_meta, s_sync, s_prev, rise_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      s_meta <= 1'b0;
      s_sync <= 1'b0;
      s_prev <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      s_meta <= shoot;
      s_sync <= s_meta;
      s_prev <= s_sync;
      rise_q <= s_sync & ~s_prev;
    end
  end

  always_comb begin
    state_d = state;
    gate_d  = gate;
    next_d  = next_q;
    cnt_d   = cnt;
    wd_d    = wd;
    fault_d = fault;
    take    = 1'b0;
    launch  = 1'b0;
    case (state)
      IDLE: begin
        gate_d = '0;
        if (rise_q && armed) launch = 1'b1;
      end
      DEAD: begin
        if (cnt <= DT_W'(1)) begin
          gate_d  = next_q;
          wd_d    = '0;
          state_d = RUN;
        end else begin
          cnt_d = cnt - DT_W'(1);
        end
      end
      RUN: begin
        if (rise_q) begin
          wd_d = '0;
          if (armed) launch = 1'b1;
        end else if (wd == WD_W'(TIMEOUT - 1)) begin
          gate_d  = '0;
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          wd_d = wd + WD_W'(1);
        end
      end
      FAULT: begin
        gate_d  = '0;
        fault_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Bits turning off drop at once; bits turning on wait out the dead-time.
    if (launch) begin
      take   = 1'b1;
      next_d = shadow;
      if (DEADTIME == 0) begin
        gate_d  = shadow;
        wd_d    = '0;
        state_d = RUN;
      end else begin
        gate_d  = gate & shadow;
        cnt_d   = DT_W'(DEADTIME);
        state_d = DEAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      gate   <= '0;
      next_q <= '0;
      cnt    <= '0;
      wd     <= '0;
      fault  <= 1'b0;
    end else begin
      state  <= state_d;
      gate   <= gate_d;
      next_q <= next_d;
      cnt    <= cnt_d;
      wd     <= wd_d;
      fault  <= fault_d;
    end
  end

  assign state_dbg = state;

`ifdef GATE_ECHO_EN
  logic [7:0] echo_buf;
  logic       echo_pend;
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_buf   <= '0;
      echo_pend  <= 1'b0;
      data_to_tx <= '0;
      start_tx   <= 1'b0;
    end else begin
      start_tx <= 1'b0;
      if (accept) begin
        echo_buf  <= data_received;
        echo_pend <= 1'b1;
      end else if (echo_pend && !tx_busy && !start_tx) begin
        // Skip the cycle right after a start so tx_busy has time to rise.
        data_to_tx <= echo_buf;
        start_tx   <= 1'b1;
        echo_pend  <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: doc/gate_cmd_receiver.md
Name: gate_cmd_receiver

Overview:
Module-side counterpart of the main FPGA's UART gate-command link. It consumes bytes from a uart_rx instance and keeps only those addressed to this module. Legal gate patterns are held in a shadow register. Each rising edge of the main FPGA's shoot line transfers the shadow pattern to the six transistor gate outputs, with dead-time insertion and a watchdog that forces all gates off if shoot pulses stop arriving.

Parameters:
MODULE_ID, 0, 2-bit address this module answers to (compared with byte bits [7:6]).
DEADTIME, 48, clk cycles between turning gates off and turning new gates on (1 us at 48 MHz); 0 allowed.
TIMEOUT, 4800000, clk cycles in RUN without a shoot edge before FAULT (100 ms at 48 MHz).

Ports:
clk  input  1  system clock, 48 MHz (SB_HFOSC).
reset  input  1  synchronous, active-high reset.
data_received  input  8  byte from uart_rx; valid when rx_done=1.
rx_done  input  1  one-cycle pulse from uart_rx when a byte completes.
parity_error  input  1  qualifies rx_done; 1 means the byte is corrupt.
shoot  input  1  asynchronous shoot line from the main FPGA.
gate  output  6  transistor gate drives; bit 2k = leg k high side, bit 2k+1 = leg k low side.
armed  output  1  a new pattern is pending in the shadow register.
frame_err  output  1  sticky flag for a rejected byte; cleared by the next accepted byte.
fault  output  1  watchdog tripped; gates held at 0.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset values: gate=0, armed=0, frame_err=0, fault=0, shadow=0, state=IDLE. Sync flops, dead-time counter and watchdog are cleared.
- A reset in any state, including mid-DEAD, takes effect on the next clk edge, and gate=0 from that edge on.
- Shoot input: 2-FF synchronizer plus an edge register. shoot_rise is a 1-cycle pulse on a 0->1 transition.
- Byte handling, on a cycle with rx_done=1:
  - parity_error=1: discard the byte, set frame_err=1.
  - Else, if bits [7:6] != MODULE_ID: ignore the byte; no flag changes.
  - Else, if any leg has both bits set (bits 2k and 2k+1 both 1): discard the byte, set frame_err=1 (shoot-through protection).
  - Else: shadow <= bits [5:0], armed <= 1, frame_err <= 0. A newer byte overwrites the pending one.
- States:
  - IDLE: gate=0. A shoot_rise with armed=1 loads next=shadow, clears armed, and goes to DEAD. A shoot_rise with armed=0 is ignored.
  - DEAD: on entry, gate <= gate & next (bits that are turning off drop immediately) and the counter loads DEADTIME. The counter decrements each cycle. At 0: gate <= next, go to RUN, watchdog cleared. With DEADTIME=0, gate <= next directly and DEAD is skipped. A shoot_rise during DEAD is ignored; armed is kept.
  - RUN: the watchdog increments each cycle.
    - A shoot_rise clears the watchdog. If armed=1, it also loads next=shadow, clears armed, and goes to DEAD.
    - A shoot_rise with armed=0 retriggers: gate is unchanged.
    - Watchdog reaching TIMEOUT-1 without a shoot_rise: gate <= 0, fault <= 1, go to FAULT.
  - FAULT: gate=0 and fault=1. Bytes are still accepted into shadow. Exit only via reset.
- Latency, from the shoot pin edge: turn-off bits drop 4 clk later; turn-on bits rise 4+DEADTIME clk later.
- Simultaneous rx_done and shoot_rise: the shoot uses the old shadow. The new byte becomes pending (armed=1) for the next shoot.
- No combinational path from any input to gate; all outputs are registered.

Optional Feature:
GATE_ECHO_EN
- Defined: adds ports data_to_tx[7:0] output, start_tx output and tx_busy input. Each accepted byte is echoed to uart_tx when tx_busy=0:
  - data_to_tx=byte, with a 1-cycle start_tx pulse.
  - A one-entry buffer holds the echo while tx_busy=1.
  - A further accepted byte overwrites the buffered echo.
  - Reset clears the buffer and start_tx.
- Undefined: these ports and the buffer do not exist; behaviour is otherwise identical.

Test Plan:
- MODULE_ID=1, DEADTIME=4. Byte 0x49 (addr 1, pattern 001001), then a shoot edge -> armed=1 after rx_done; gate=001001 exactly 8 clk after the shoot pin edge; armed=0.
- From gate=001001, byte 0x46 (pattern 000110), then shoot -> gate=000000 at +4 clk (bits 0 and 3 drop) and 000110 at +8 clk; no cycle has both bits of a leg high.
- Byte 0x43 (leg 0 both on) -> frame_err=1, armed unchanged, gate unchanged. Byte 0x09 (addr 0) -> ignored, frame_err still 1. rx_done with parity_error=1 -> frame_err=1.
- In RUN with TIMEOUT=100, no shoot for 100 clk -> gate=0 and fault=1. Further shoots and valid bytes leave gate=0 until reset.
- rx_done with byte 0x52 in the same cycle as shoot_rise, with old shadow 0x49 armed -> gate takes 001001; armed=1 afterwards; the next shoot applies 010010.
- Reset asserted mid-DEAD -> gate=0, state IDLE, armed=0, next cycle; a later shoot with no byte received leaves gate=0.
